// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int PISO_WIDTH_DEFAULT = 4;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: MSB-first, one bit per clk, with a one-word
// holding slot so consecutive frames stream with no idle cycle between them.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] par_i,
    input  logic             par_valid_i,
    output logic             par_ready_o,
    output logic             ser_o,
    output logic             ser_valid_o,
    output logic             frame_o,
    output logic             busy_o
);

    localparam int            CW      = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shifter_q, shifter_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             hold_valid_q, hold_valid_d;
    logic             accept;
    logic             load;
    logic             shifting;

    // A reset mid-frame drops the partial word entirely; nothing resumes afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shifter_q    <= '0;
            bit_cnt_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shifter_q    <= shifter_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shifter_d    = shifter_q;
        bit_cnt_d    = bit_cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        accept       = par_valid_i && !hold_valid_q;
        load         = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_valid_q) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shifter_d = shifter_q << 1;
                if (bit_cnt_q == '0) begin
                    if (hold_valid_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
        endcase

        // Accept and load never coincide: accept needs an empty slot, load a full one.
        if (load) begin
            shifter_d    = hold_q;
            bit_cnt_d    = CNT_TOP;
            hold_valid_d = 1'b0;
        end
        if (accept) begin
            hold_d       = par_i;
            hold_valid_d = 1'b1;
        end
    end

    always_comb begin
        shifting    = (state_q == SHIFT);
        ser_valid_o = shifting;
        ser_o       = shifting & shifter_q[WIDTH-1];
        frame_o     = shifting && (bit_cnt_q == CNT_TOP);
        busy_o      = shifting || hold_valid_q;
        par_ready_o = !hold_valid_q;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: WIDTH=4 and WIDTH=8 instances, a loopback
// receiver model on the 4-bit link, and directed cycle checks.
module tb_piso_serializer;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] par4   = '0;
    logic       valid4 = 1'b0;
    logic       ready4, ser4, sv4, frame4, busy4;
    logic [7:0] par8   = '0;
    logic       valid8 = 1'b0;
    logic       ready8, ser8, sv8, frame8, busy8;

    int checks = 0;
    int passes = 0;

    logic [3:0] exp4[$];
    logic [7:0] exp8[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .par_i(par4), .par_valid_i(valid4),
        .par_ready_o(ready4), .ser_o(ser4), .ser_valid_o(sv4),
        .frame_o(frame4), .busy_o(busy4)
    );

    piso_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .par_i(par8), .par_valid_i(valid8),
        .par_ready_o(ready8), .ser_o(ser8), .ser_valid_o(sv8),
        .frame_o(frame8), .busy_o(busy8)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    // Called at a negedge; the transfer happens on the posedge where valid & ready.
    task automatic applyStimulus(input bit use8, input logic [7:0] w);
        int guard = 0;
        if (use8) begin
            par8 = w; valid8 = 1'b1;
            while (!ready8 && guard < 100) begin @(negedge clk); guard++; end
            if (guard >= 100) reportTimeout("send8");
            else exp8.push_back(w);
            @(negedge clk);
            valid8 = 1'b0;
        end else begin
            par4 = w[3:0]; valid4 = 1'b1;
            while (!ready4 && guard < 100) begin @(negedge clk); guard++; end
            if (guard >= 100) reportTimeout("send4");
            else exp4.push_back(w[3:0]);
            @(negedge clk);
            valid4 = 1'b0;
        end
    endtask

    task automatic waitIdle(input bit use8);
        int guard = 0;
        while ((use8 ? (busy8 || sv8) : (busy4 || sv4)) && guard < 300) begin
            @(negedge clk); guard++;
        end
        if (guard >= 300) reportTimeout("wait_idle");
        @(negedge clk);
    endtask

    task automatic expectFrame4(input string name, input logic [3:0] bits);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput({name, "_ser"}, ser4, bits[3-i]);
            checkOutput({name, "_valid"}, sv4, 1'b1);
            checkOutput({name, "_frame"}, frame4, i == 0);
        end
    endtask

    // Loopback receiver: plain 4-bit shift register fed by the serial link.
    logic [3:0] rx4 = '0;
    always @(posedge clk) if (sv4) rx4 <= {rx4[2:0], ser4};

    // Reference model: the serial stream is the accepted words concatenated MSB-first.
    int         cyc4   = 0;
    int         nbits4 = 0;
    logic [3:0] acc4   = '0;
    int         rx_due[$];
    logic [3:0] rx_exp[$];
    always @(negedge clk) begin
        cyc4++;
        if (!rst_n) begin
            exp4.delete(); rx_due.delete(); rx_exp.delete();
            nbits4 = 0; acc4 = '0;
        end else begin
            if (rx_due.size() > 0 && rx_due[0] == cyc4) begin
                void'(rx_due.pop_front());
                if (rx_exp.size() > 0) checkOutput("rx_word", rx4, rx_exp.pop_front());
                else reportTimeout("rx_word_missing");
            end
            if (sv4) begin
                checkOutput("frame_align4", frame4, nbits4 == 0);
                if (frame4) rx_due.push_back(cyc4 + 4);
                acc4 = {acc4[2:0], ser4};
                nbits4++;
                if (nbits4 == 4) begin
                    nbits4 = 0;
                    if (exp4.size() == 0) checkOutput("unexpected_word4", acc4, 32'hFFFF_FFFF);
                    else begin
                        rx_exp.push_back(exp4[0]);
                        checkOutput("word4", acc4, exp4.pop_front());
                    end
                end
            end else begin
                checkOutput("idle_ser4", ser4, 1'b0);
            end
        end
    end

    int         nbits8 = 0;
    logic [7:0] acc8   = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp8.delete(); nbits8 = 0; acc8 = '0;
        end else if (sv8) begin
            checkOutput("frame_align8", frame8, nbits8 == 0);
            acc8 = {acc8[6:0], ser8};
            nbits8++;
            if (nbits8 == 8) begin
                nbits8 = 0;
                if (exp8.size() == 0) checkOutput("unexpected_word8", acc8, 32'hFFFF_FFFF);
                else checkOutput("word8", acc8, exp8.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] stream, frames, readys;
        logic [7:0] w81;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            par4 = 4'($urandom); valid4 = 1'($urandom);
            par8 = 8'($urandom); valid8 = 1'($urandom);
            @(negedge clk);
            checkOutput("rst_ser_valid", sv4, 1'b0);
            checkOutput("rst_ser", ser4, 1'b0);
            checkOutput("rst_ready", ready4, 1'b1);
            checkOutput("rst_busy", busy4, 1'b0);
            checkOutput("rst_frame", frame4, 1'b0);
        end
        valid4 = 1'b0; valid8 = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Single word
        applyStimulus(1'b0, 8'h0B);
        checkOutput("t2_busy_hold", busy4, 1'b1);
        checkOutput("t2_no_bypass", sv4, 1'b0);
        expectFrame4("t2", 4'b1011);
        @(negedge clk);
        checkOutput("t2_idle_valid", sv4, 1'b0);
        checkOutput("t2_idle_busy", busy4, 1'b0);
        checkOutput("t2_idle_ready", ready4, 1'b1);

        // Back-to-back with valid held high
        stream = '0; frames = '0; readys = '0;
        fork
            begin
                applyStimulus(1'b0, 8'h0A);
                applyStimulus(1'b0, 8'h05);
            end
            begin
                int guard = 0;
                while (!sv4 && guard < 20) begin @(negedge clk); guard++; end
                if (guard >= 20) reportTimeout("t3_start");
                for (int i = 0; i < 8; i++) begin
                    stream[7-i] = ser4; frames[7-i] = frame4; readys[7-i] = ready4;
                    if (i < 7) @(negedge clk);
                end
            end
        join
        checkOutput("t3_stream", stream, 8'b1010_0101);
        checkOutput("t3_frames", frames, 8'b1000_1000);
        checkOutput("t3_ready", readys, 8'b1000_1111);
        waitIdle(1'b0);

        // Random words through the loopback receiver
        for (int n = 0; n < 16; n++) begin
            repeat ($urandom_range(0, 2)) begin
                valid4 = 1'b0; par4 = 4'($urandom);
                @(negedge clk);
            end
            applyStimulus(1'b0, 8'($urandom));
        end
        waitIdle(1'b0);

        // Reset mid-word, then a clean word
        applyStimulus(1'b0, 8'h0F);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_valid_clr", sv4, 1'b0);
        checkOutput("t5_ser_clr", ser4, 1'b0);
        checkOutput("t5_frame_clr", frame4, 1'b0);
        checkOutput("t5_busy_clr", busy4, 1'b0);
        checkOutput("t5_ready_set", ready4, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 8'h03);
        expectFrame4("t5", 4'b0011);
        waitIdle(1'b0);

        // WIDTH=8 instance
        w81 = 8'h81;
        applyStimulus(1'b1, w81);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("t6_ser", ser8, w81[7-i]);
            checkOutput("t6_frame", frame8, i == 0);
        end
        for (int n = 0; n < 10; n++) begin
            repeat ($urandom_range(0, 3)) begin
                valid8 = 1'b0; par8 = 8'($urandom);
                @(negedge clk);
            end
            applyStimulus(1'b1, 8'($urandom));
        end
        waitIdle(1'b1);

        checkOutput("all_words4_out", exp4.size(), 0);
        checkOutput("all_words8_out", exp8.size(), 0);
        checkOutput("rx_all_checked", rx_exp.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
